sipo_frame_rx: RTL and testbench
================================

# sipo_frame_rx

Serial-in, parallel-out frame receiver that consumes the single-bit stream produced by the team's PISO shift stage and reassembles it into WIDTH-bit words. It detects a start bit on an idle-low line, shifts in WIDTH data bits MSB first, and presents each completed word on a registered parallel port with a valid/ready handshake. Words that complete while the output holder is still full are dropped and flagged by a sticky overrun flag.

## Interface
- WIDTH, 4, data bits per frame; must be ≥2.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low (rst=0 at a rising edge resets the block).
- sin  input  1  serial line from PISO stage; idle level 0.
- sin_en  input  1  bit strobe; sin is sampled only on cycles with sin_en=1. Tie to 1 for one bit per clock.
- pout  output  WIDTH  received word, MSB = first data bit received.
- pvalid  output  1  pout holds an unconsumed word.
- pready  input  1  consumer accepts pout on a cycle with pvalid=1 and pready=1.
- overrun  output  1  sticky: a completed word was dropped because pvalid=1 and pready=0.
- parity_err  output  1  parity mismatch on the word currently in pout (see Configuration).

## Operation
- FSM states: IDLE, DATA, PAR (PAR exists only with PARITY_EN).
- IDLE: on a sampled sin=1 (start bit), clear shift register and bit counter, go to DATA. Sampled sin=0 keeps IDLE.
- DATA: each sampled bit shifts in at LSB (shreg <= {shreg[WIDTH-2:0], sin}); counter increments. After the WIDTH-th data bit: go to PAR if enabled, else complete the frame and return to IDLE.
- PAR: sample one parity bit, complete the frame, return to IDLE.
- Frame completion (the edge that samples the last bit of the frame):
  - If pvalid=0, or pvalid=1 and pready=1: load pout with the assembled word, pvalid<=1, load parity_err.
  - If pvalid=1 and pready=0: drop the word, hold pout/pvalid/parity_err, set overrun<=1.
- A handshake (pvalid & pready) with no simultaneous completion: pvalid<=0; pout holds its last value.
- A completion and a handshake in the same cycle: old word consumed, new word loaded, pvalid stays 1.
- Cycles with sin_en=0 freeze FSM, counter and shift register; the handshake still operates.
- No back-to-back gap required: a start bit may be sampled on the first sin_en cycle after a frame completes.
- overrun clears only on reset.
- Bit counter width is $clog2(WIDTH+1); wraps only via reset to 0 on start-bit detection.

## Timing
- Reset values: pout=0, pvalid=0, overrun=0, parity_err=0, FSM=IDLE, counter=0, shift register=0.
- Reset mid-frame aborts the frame with no output; the next frame requires a new start bit.
- Latency: with sin_en=1, start bit sampled at edge N and data bits at edges N+1..N+WIDTH; pvalid and pout are visible after edge N+WIDTH (N+WIDTH+1 with PARITY_EN).
- Frame length on the line: 1+WIDTH bits (2+WIDTH with PARITY_EN).
- pout, pvalid, overrun and parity_err are registered outputs with no combinational path from any input.

## Configuration
- SIPO_PARITY_EN defined: each frame carries one even-parity bit after the data. Completion occurs at the PAR sample. parity_err = ^{data, parity bit}, stored with the word. The word is delivered regardless of parity_err.
- SIPO_PARITY_EN undefined: there is no PAR state, frames are 1+WIDTH bits, and parity_err is tied to 0. The port list is identical in both builds.

## Test plan
- Basic receive, WIDTH=4, no parity, pready=1, sin_en=1: drive sin 1,1,0,1,0 -> pout=4'b1010 and pvalid=1 after the 5th edge; pvalid=0 one cycle later.
- Backpressure and overrun: with pready=0, send frame 1010, then frame 0110 -> pout stays 1010 and overrun=1. Raise pready -> pvalid drops, and overrun remains 1.
- Simultaneous completion and accept: pvalid=1 (word 1010); pready=1 on the completion edge of frame 0011 -> pout=0011, pvalid stays 1, overrun=0.
- Stall: data bits of 1001 interleaved with sin_en=0 cycles carrying garbage on sin -> pout=1001; garbage is ignored.
- Reset mid-frame: rst=0 after 2 data bits -> all outputs 0 and FSM in IDLE. A complete frame 0101 afterwards -> pout=0101.
- With SIPO_PARITY_EN: frame 1,1,0,1,0,0 -> pout=1010, parity_err=0. Frame 1,1,0,1,0,1 -> pout=1010, parity_err=1.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// Serial-in, parallel-out frame receiver.
// Detects a start bit on an idle-low line, shifts in WIDTH data bits MSB first and presents
// each completed word on a registered valid/ready port. Words completing while the holder is
// still full are dropped and flagged by a sticky overrun flag.
// Optional feature: define SIPO_PARITY_EN to expect one even-parity bit after the data bits;
// parity_err then reports the parity check of the word held in pout, otherwise it stays 0.

module sipo_frame_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  input  logic             pready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {StIdle, StData, StPar} state_e;
`else
  typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  pout_q, pout_d;
  logic              pvalid_q, pvalid_d;
  logic              overrun_q, overrun_d;
  logic              perr_q, perr_d;

  // Frame completion strobe with the assembled word and its parity result.
  logic              complete;
  logic [WIDTH-1:0]  frame_word;
  logic              frame_perr;

  // Receive FSM next state: all of it is frozen on cycles without a bit strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    complete   = 1'b0;
    frame_word = shreg_q;
    frame_perr = 1'b0;
    if (sin_en) begin
      unique case (state_q)
        StIdle: begin
          if (sin) begin
            state_d = StData;
            cnt_d   = '0;
            shreg_d = '0;
          end
        end
        StData: begin
          shreg_d = {shreg_q[WIDTH-2:0], sin};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
            state_d = StPar;
`else
            state_d    = StIdle;
            complete   = 1'b1;
            frame_word = {shreg_q[WIDTH-2:0], sin};
`endif
          end
        end
`ifdef SIPO_PARITY_EN
        StPar: begin
          state_d    = StIdle;
          complete   = 1'b1;
          frame_word = shreg_q;
          frame_perr = ^{shreg_q, sin};
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Output holder: load on completion when free or being drained, otherwise drop and flag.
  always_comb begin
    pout_d    = pout_q;
    pvalid_d  = pvalid_q;
    overrun_d = overrun_q;
    perr_d    = perr_q;
    if (complete) begin
      if (!pvalid_q || pready) begin
        pout_d   = frame_word;
        pvalid_d = 1'b1;
        perr_d   = frame_perr;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pvalid_q && pready) begin
      pvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      pout_q    <= '0;
      pvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      pout_q    <= pout_d;
      pvalid_q  <= pvalid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign pout       = pout_q;
  assign pvalid     = pvalid_q;
  assign overrun    = overrun_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed self-checking bench for sipo_frame_rx (WIDTH=4).
// Parity cases run only when SIPO_PARITY_EN is defined.

module tb_sipo_frame_rx;

`ifdef SIPO_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic [3:0] pout;
  logic       pvalid;
  logic       pready;
  logic       overrun;
  logic       parity_err;

  int n_cmp = 0;
  int n_err = 0;

  sipo_frame_rx #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .pout      (pout),
    .pvalid    (pvalid),
    .pready    (pready),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one line cycle, then sample 1 time unit after the edge.
  task automatic send_bit(input logic b, input logic en);
    sin    = b;
    sin_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    sin    = 1'b0;
    sin_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Start bit, data MSB first, parity bit if enabled; rdy_last raises pready for the final bit.
  task automatic send_frame(input logic [3:0] d, input logic par_flip, input logic rdy_last);
    send_bit(1'b1, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      if (rdy_last && i == 0 && !Par) pready = 1'b1;
      send_bit(d[i], 1'b1);
    end
    if (Par) begin
      if (rdy_last) pready = 1'b1;
      send_bit((^d) ^ par_flip, 1'b1);
    end
  endtask

  initial begin
    rst    = 1'b0;
    sin    = 1'b0;
    sin_en = 1'b0;
    pready = 1'b0;
    do_reset();
    check_eq("rst_pout", pout, 4'h0);
    check_eq("rst_pvalid", pvalid, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_perr", parity_err, 1'b0);

    // Basic receive, bit by bit to pin latency.
    pready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    check_eq("basic_early_pvalid", pvalid, 1'b0);
    send_bit(1'b0, 1'b1);
    if (Par) begin
      check_eq("basic_prepar_pvalid", pvalid, 1'b0);
      send_bit(1'b0, 1'b1);
    end
    check_eq("basic_pout", pout, 4'b1010);
    check_eq("basic_pvalid", pvalid, 1'b1);
    check_eq("basic_perr", parity_err, 1'b0);
    send_bit(1'b0, 1'b1);
    check_eq("basic_drain_pvalid", pvalid, 1'b0);
    check_eq("basic_hold_pout", pout, 4'b1010);

    // Backpressure and overrun.
    do_reset();
    pready = 1'b0;
    send_frame(4'b1010, 1'b0, 1'b0);
    check_eq("bp_first_pout", pout, 4'b1010);
    check_eq("bp_first_pvalid", pvalid, 1'b1);
    check_eq("bp_first_overrun", overrun, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    check_eq("bp_drop_pout", pout, 4'b1010);
    check_eq("bp_drop_pvalid", pvalid, 1'b1);
    check_eq("bp_overrun", overrun, 1'b1);
    pready = 1'b1;
    send_bit(1'b0, 1'b1);
    check_eq("bp_drain_pvalid", pvalid, 1'b0);
    check_eq("bp_sticky_overrun", overrun, 1'b1);

    // Completion and accept on the same edge.
    do_reset();
    check_eq("ovr_cleared", overrun, 1'b0);
    pready = 1'b0;
    send_frame(4'b1010, 1'b0, 1'b0);
    check_eq("sim_first_pvalid", pvalid, 1'b1);
    send_frame(4'b0011, 1'b0, 1'b1);
    check_eq("sim_pout", pout, 4'b0011);
    check_eq("sim_pvalid", pvalid, 1'b1);
    check_eq("sim_overrun", overrun, 1'b0);

    // Stall: sin_en=0 cycles carry garbage that must be ignored, including before the start bit.
    do_reset();
    pready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("stall_idle_pvalid", pvalid, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    check_eq("stall_mid_pvalid", pvalid, 1'b0);
    send_bit(1'b1, 1'b1);
    if (Par) begin
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
    end
    check_eq("stall_pout", pout, 4'b1001);
    check_eq("stall_pvalid", pvalid, 1'b1);
    check_eq("stall_perr", parity_err, 1'b0);

    // Reset mid-frame (holder full beforehand).
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    rst = 1'b0;
    send_bit(1'b1, 1'b1);
    check_eq("mid_rst_pout", pout, 4'h0);
    check_eq("mid_rst_pvalid", pvalid, 1'b0);
    check_eq("mid_rst_overrun", overrun, 1'b0);
    check_eq("mid_rst_perr", parity_err, 1'b0);
    rst = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    check_eq("post_rst_early_pvalid", pvalid, 1'b0);
    send_bit(1'b1, 1'b1);
    if (Par) send_bit(1'b0, 1'b1);
    check_eq("post_rst_pout", pout, 4'b0101);
    check_eq("post_rst_pvalid", pvalid, 1'b1);

    if (Par) begin
      do_reset();
      pready = 1'b1;
      send_frame(4'b1010, 1'b0, 1'b0);
      check_eq("par_ok_pout", pout, 4'b1010);
      check_eq("par_ok_perr", parity_err, 1'b0);
      send_bit(1'b0, 1'b1);
      send_frame(4'b1010, 1'b1, 1'b0);
      check_eq("par_bad_pout", pout, 4'b1010);
      check_eq("par_bad_pvalid", pvalid, 1'b1);
      check_eq("par_bad_perr", parity_err, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
